// File: rtl/mult_pkg.sv
// Types and constants shared by the Booth multiplier and the product accumulator.
package mult_pkg;

   localparam int unsigned N_DEFAULT = 4;

   typedef enum logic {
      ACC,
      HOLD
   } acc_state_t;

endpackage

// File: rtl/sat_add.sv
// Signed W-bit adder with overflow detect; clamps to the signed range when
// PRODUCT_ACCUMULATOR_SAT_EN is defined, otherwise wraps modulo 2^W.
module sat_add #(
   parameter int unsigned W = 10
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   logic [W-1:0] raw;

   always_comb begin
      raw = a + b;
      // Overflow when both operands share a sign the result does not.
      ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
      if (ovf) begin
         sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         sum = raw;
      end
`else
      sum = raw;
`endif
   end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates LEN signed products into one dot-product and hands it off with a
// valid/ready pair. Define PRODUCT_ACCUMULATOR_SAT_EN for saturating adds.
module product_accumulator
   import mult_pkg::*;
#(
   parameter int unsigned N     = N_DEFAULT,
   parameter int unsigned LEN   = 4,
   parameter int unsigned ACC_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*N-1:0]   in_prod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf
);

   localparam int unsigned CntW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(LEN - 1);

   acc_state_t       state_q;
   logic [ACC_W-1:0] acc_q;
   logic [CntW-1:0]  cnt_q;
   logic             ovf_q;

   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] add_sum;
   logic             add_ovf;

   assign prod_ext = ACC_W'($signed(in_prod));

   sat_add #(
      .W(ACC_W)
   ) u_sat_add (
      .a  (acc_q),
      .b  (prod_ext),
      .sum(add_sum),
      .ovf(add_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_q <= ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ACC: begin
               if (in_valid) begin
                  acc_q <= add_sum;
                  ovf_q <= ovf_q | add_ovf;
                  if (cnt_q == CntLast) begin
                     cnt_q   <= '0;
                     state_q <= HOLD;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q <= ACC;
                  acc_q   <= '0;
                  ovf_q   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign in_ready  = (state_q == ACC);
   assign out_valid = (state_q == HOLD);
   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench: a default instance (ACC_W=10) and an ACC_W=8 instance for overflow.
module tb_product_accumulator;

   logic       clk = 1'b0;
   logic       rst, clr, in_valid, out_ready;
   logic [7:0] in_prod;

   logic       a_in_ready, a_out_valid, a_out_ovf;
   logic [9:0] a_out_sum;
   logic       b_in_ready, b_out_valid, b_out_ovf;
   logic [7:0] b_out_sum;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   product_accumulator #(.N(4), .LEN(4), .ACC_W(10)) dut_a (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_prod(in_prod), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_sum(a_out_sum), .out_ovf(a_out_ovf)
   );

   product_accumulator #(.N(4), .LEN(4), .ACC_W(8)) dut_b (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_prod(in_prod), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_sum(b_out_sum), .out_ovf(b_out_ovf)
   );

   typedef struct {
      logic       valid;
      logic       ordy;
      logic [7:0] prod;
      logic       exp_in_ready;
      logic       exp_out_valid;
      logic       chk_sum;
      logic [9:0] exp_sum;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] p, input logic ordy, input logic c);
      in_valid  = v;
      in_prod   = p;
      out_ready = ordy;
      clr       = c;
      tick();
   endtask

   task automatic feed4(input logic [7:0] p);
      for (int i = 0; i < 4; i++) drive(1'b1, p, 1'b0, 1'b0);
   endtask

   initial begin
      // Basic sum then backpressure and handoff; 0x55 must be ignored while held.
      vecs[0] = '{1'b1, 1'b0, 8'h06, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 8'hF1, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 8'h31, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 8'hF8, 1'b0, 1'b1, 1'b1, 10'h020, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 10'h020, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 10'h020, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 10'h020, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 10'h000, 1'b0};
      vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 10'h000, 1'b0};
      vecs[9] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 10'h000, 1'b0};

      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_prod = '0;
      tick();
      tick();
      rst = 1'b0;
      check("reset in_ready", 32'(a_in_ready), 32'd1);
      check("reset out_valid", 32'(a_out_valid), 32'd0);
      check("reset out_sum", 32'(a_out_sum), 32'd0);
      check("reset out_ovf", 32'(a_out_ovf), 32'd0);

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].valid, vecs[i].prod, vecs[i].ordy, 1'b0);
         check($sformatf("vec%0d in_ready", i), 32'(a_in_ready), 32'(vecs[i].exp_in_ready));
         check($sformatf("vec%0d out_valid", i), 32'(a_out_valid), 32'(vecs[i].exp_out_valid));
         check($sformatf("vec%0d out_ovf", i), 32'(a_out_ovf), 32'(vecs[i].exp_ovf));
         if (vecs[i].chk_sum)
            check($sformatf("vec%0d out_sum", i), 32'(a_out_sum), 32'(vecs[i].exp_sum));
      end
      // vec9 was a zero accept; finish that dot-product and hand it off.
      for (int i = 0; i < 3; i++) drive(1'b1, 8'h00, 1'b0, 1'b0);
      check("zero dot valid", 32'(a_out_valid), 32'd1);
      drive(1'b0, 8'h00, 1'b1, 1'b0);

      // Gaps between accepts.
      drive(1'b1, 8'h02, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 8'h7F, 1'b0, 1'b0);
         check("gap no valid", 32'(a_out_valid), 32'd0);
      end
      drive(1'b1, 8'h03, 1'b0, 1'b0);
      drive(1'b1, 8'h04, 1'b0, 1'b0);
      check("gap 3rd no valid", 32'(a_out_valid), 32'd0);
      drive(1'b1, 8'h05, 1'b0, 1'b0);
      check("gap valid", 32'(a_out_valid), 32'd1);
      check("gap sum", 32'(a_out_sum), 32'h00E);
      drive(1'b0, 8'h00, 1'b1, 1'b0);

      // clr collides with an accept.
      drive(1'b1, 8'h10, 1'b0, 1'b0);
      drive(1'b1, 8'h10, 1'b0, 1'b0);
      drive(1'b1, 8'h10, 1'b0, 1'b1);
      check("clr sum", 32'(a_out_sum), 32'd0);
      check("clr in_ready", 32'(a_in_ready), 32'd1);
      feed4(8'h01);
      check("clr then sum", 32'(a_out_sum), 32'h004);
      check("clr then valid", 32'(a_out_valid), 32'd1);
      // clr in HOLD drops the pending result.
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      check("clr hold drop", 32'(a_out_valid), 32'd0);
      check("clr hold sum", 32'(a_out_sum), 32'd0);

      // Reset mid-accumulation.
      drive(1'b1, 8'h01, 1'b0, 1'b0);
      drive(1'b1, 8'h01, 1'b0, 1'b0);
      rst = 1'b1;
      drive(1'b1, 8'h01, 1'b0, 1'b0);
      rst = 1'b0;
      check("rst mid valid", 32'(a_out_valid), 32'd0);
      check("rst mid sum", 32'(a_out_sum), 32'd0);
      check("rst mid in_ready", 32'(a_in_ready), 32'd1);
      feed4(8'h01);
      check("rst then sum", 32'(a_out_sum), 32'h004);
      check("rst then valid", 32'(a_out_valid), 32'd1);
      rst = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      check("rst hold valid", 32'(a_out_valid), 32'd0);

      // Overflow on the 8-bit accumulator.
      feed4(8'h40);
      check("ovf valid", 32'(b_out_valid), 32'd1);
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
      check("ovf sum", 32'(b_out_sum), 32'h7F);
`else
      check("ovf sum", 32'(b_out_sum), 32'h00);
`endif
      check("ovf flag", 32'(b_out_ovf), 32'd1);
      check("no ovf wide sum", 32'(a_out_sum), 32'h100);
      check("no ovf wide flag", 32'(a_out_ovf), 32'd0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check("ovf cleared", 32'(b_out_ovf), 32'd0);
      check("ovf sum cleared", 32'(b_out_sum), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
